// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and IDLE->ACCESS->RESP sequencer for a single-port data memory
//   Ports: clk/reset (async, active-low); per port N in {0,1}: reqN, weN, addrN, wdataN in,
//   gntN (combinational accept), rvalidN (one-cycle completion), rdataN out;
//   mem_address/mem_write_data/mem_write to the memory, mem_read_data from it;
//   contention_cnt counts IDLE cycles with both requests (built only with ARB_PERF_CNT_EN).
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  contention_cnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  // last_q doubles as the id of the access in flight: both are written only at the accept edge.
  logic last_q, last_d;
  logic win1, idle, acc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, resp_q, resp_d;
  logic we_q, we_d;
  always_comb begin
    idle    = state_q == IDLE;
    win1    = req1 & (~req0 | ~last_q);
    gnt1    = idle & win1;
    gnt0    = idle & req0 & ~win1;
    acc     = gnt0 | gnt1;
    state_d = idle ? ((req0 | req1) ? ACCESS : IDLE) : (state_q == ACCESS ? RESP : IDLE);
    last_d  = acc ? gnt1 : last_q;
    // Memory pins load only on the accept edge and clear on the next one, so they are live for exactly the ACCESS cycle.
    we_d    = acc & (gnt1 ? we1 : we0);
    addr_d  = acc ? (gnt1 ? addr1 : addr0) : '0;
    wdata_d = acc ? (gnt1 ? wdata1 : wdata0) : '0;
    resp_d  = state_q == ACCESS ? (we_q ? '0 : mem_read_data) : resp_q;
    rvalid0 = state_q == RESP & ~last_q;
    rvalid1 = state_q == RESP & last_q;
    rdata0  = rvalid0 ? resp_q : '0;
    rdata1  = rvalid1 ? resp_q : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
    end
  assign mem_write      = we_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (idle & req0 & req1 & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign contention_cnt = cnt_q;
`else
  assign contention_cnt = '0;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int CW = 4;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [15:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;
  logic [CW-1:0] contention_cnt;
  logic [15:0] mem [256];
  logic init_done = 1'b0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .contention_cnt(contention_cnt));

  // Behavioural single-port memory: combinational read, write on the rising edge.
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk)
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 | 16'(i);
      mem[5] <= 16'h1234;
      init_done <= 1'b1;
    end else if (mem_write) mem[mem_address[7:0]] <= mem_write_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    logic win;
    logic [15:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r0, r1, w0, w1, input logic [15:0] a0, a1, d0, d1,
                              input logic win, input logic [15:0] rd);
    mk.r0 = r0; mk.r1 = r1; mk.w0 = w0; mk.w1 = w1;
    mk.a0 = a0; mk.a1 = a1; mk.d0 = d0; mk.d1 = d1;
    mk.win = win; mk.rd = rd;
  endfunction

  vec_t v [8];

  initial begin
    // Winner column assumes last=1 after reset and strict alternation on ties.
    v[0] = mk(1, 0, 0, 0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 0, 16'h1234);
    v[1] = mk(0, 1, 0, 1, 16'h0000, 16'h0010, 16'h0000, 16'hBEEF, 1, 16'h0000);
    v[2] = mk(1, 0, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 16'hBEEF);
    v[3] = mk(1, 1, 0, 0, 16'h0005, 16'h0010, 16'h0000, 16'h0000, 1, 16'hBEEF);
    v[4] = mk(1, 1, 1, 0, 16'h0020, 16'h0005, 16'h5A5A, 16'h0000, 0, 16'h0000);
    v[5] = mk(0, 1, 0, 0, 16'h0000, 16'h0020, 16'h0000, 16'h0000, 1, 16'h5A5A);
    v[6] = mk(1, 1, 0, 1, 16'h0020, 16'h0030, 16'h0000, 16'h0F0F, 0, 16'h5A5A);
    v[7] = mk(1, 0, 0, 0, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 0, 16'hA030);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_cnt", contention_cnt, 0);
    reset = 1'b1;

    foreach (v[i]) begin
      @(posedge clk); #1;
      {req0, req1, we0, we1} = {v[i].r0, v[i].r1, v[i].w0, v[i].w1};
      {addr0, addr1, wdata0, wdata1} = {v[i].a0, v[i].a1, v[i].d0, v[i].d1};
      @(negedge clk);
      chk($sformatf("v%0d_gnt0", i), gnt0, !v[i].win);
      chk($sformatf("v%0d_gnt1", i), gnt1, v[i].win);
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      @(negedge clk);
      chk($sformatf("v%0d_gnt_access", i), {gnt0, gnt1}, 0);
      chk($sformatf("v%0d_mem_write", i), mem_write, v[i].win ? v[i].w1 : v[i].w0);
      chk($sformatf("v%0d_mem_address", i), mem_address, v[i].win ? v[i].a1 : v[i].a0);
      if (v[i].win ? v[i].w1 : v[i].w0)
        chk($sformatf("v%0d_mem_wdata", i), mem_write_data, v[i].win ? v[i].d1 : v[i].d0);
      @(negedge clk);
      chk($sformatf("v%0d_mem_write_resp", i), mem_write, 0);
      chk($sformatf("v%0d_rvalid0", i), rvalid0, !v[i].win);
      chk($sformatf("v%0d_rvalid1", i), rvalid1, v[i].win);
      chk($sformatf("v%0d_rdata0", i), rdata0, v[i].win ? 16'h0 : v[i].rd);
      chk($sformatf("v%0d_rdata1", i), rdata1, v[i].win ? v[i].rd : 16'h0);
    end

    // Reset asserted in the middle of a write ACCESS cycle.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 16'h0040; wdata0 = 16'h1111;
    @(negedge clk);
    chk("mid_gnt0", gnt0, 1);
    @(posedge clk); #1;
    req0 = 0; we0 = 0;
    @(negedge clk);
    chk("mid_mem_write_pre", mem_write, 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_mem_write_drop", mem_write, 0);
    chk("mid_mem_address_drop", mem_address, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_rvalid_c%0d", c), {rvalid0, rvalid1}, 0);
    end
    chk("mid_mem_unchanged", mem[8'h40], 16'hA040);

    // Both ports held requesting: grants alternate 0,1,0,1 every third cycle.
    @(posedge clk); #1;
    req0 = 1; req1 = 1; addr0 = 16'h0005; addr1 = 16'h0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("tie_c%0d_gnt0", c), gnt0, (c % 3 == 0) && ((c / 3) % 2 == 0));
      chk($sformatf("tie_c%0d_gnt1", c), gnt1, (c % 3 == 0) && ((c / 3) % 2 == 1));
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
    chk("cnt_after_4_ties", contention_cnt, PERF ? 4 : 0);
    @(posedge clk); #1;
    req0 = 1; req1 = 1;
    repeat (60) @(posedge clk);
    #1 req0 = 0; req1 = 0;
    @(negedge clk);
    chk("cnt_saturated", contention_cnt, PERF ? 4'hF : 4'h0);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
